// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and round-robin search helper for decoder_rr_arbiter.
package arb_pkg;

  localparam int N            = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // First set bit of req searching ptr, ptr+1, ... wrapping; callers only use it when req != 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] k;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = ptr + IDX_W'(i);
      if (!found && req[k]) begin
        rr_pick = k;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_onehot_decoder3to8.sv
// Gate-level 3-to-8 one-hot decoder with enable; drives the arbiter chip-selects.
module onehot_decoder3to8 (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] out
);

  assign out[0] = en & ~idx[2] & ~idx[1] & ~idx[0];
  assign out[1] = en & ~idx[2] & ~idx[1] &  idx[0];
  assign out[2] = en & ~idx[2] &  idx[1] & ~idx[0];
  assign out[3] = en & ~idx[2] &  idx[1] &  idx[0];
  assign out[4] = en &  idx[2] & ~idx[1] & ~idx[0];
  assign out[5] = en &  idx[2] & ~idx[1] &  idx[0];
  assign out[6] = en &  idx[2] &  idx[1] & ~idx[0];
  assign out[7] = en &  idx[2] &  idx[1] &  idx[0];

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter with registered owner index and decoded one-hot grant.
// Define ARB_TIMEOUT_EN to add a hold counter that revokes a grant after MAX_HOLD cycles.
//
// state   | meaning
// IDLE    | no owner; arbitrate from ptr on the sampled req
// GRANT   | owner grant_idx holds the resource
// RELEASE | one-cycle turnaround, ptr moves past the last owner
module decoder_rr_arbiter
  import arb_pkg::*;
  #(parameter int unsigned MAX_HOLD = MAX_HOLD_DEF)
  (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             valid_q;

  assign idx_d = rr_pick(req, ptr_q);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            idx_q   <= idx_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx_q]) begin
            valid_q <= 1'b0;
            state_q <= RELEASE;
          end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            // this cycle is the MAX_HOLD-th granted cycle: revoke while still requested
            hold_q    <= hold_q + 1'b1;
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RELEASE: begin
          ptr_q   <= idx_q + 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            idx_q   <= idx_d;
            valid_q <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx_q]) begin
            valid_q <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          ptr_q   <= idx_q + 1'b1;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

  onehot_decoder3to8 u_dec (
    .en  (valid_q),
    .idx (idx_q),
    .out (grant)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed self-checking bench for decoder_rr_arbiter; build with or without ARB_TIMEOUT_EN.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    tick(3);
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: grant=%h valid=%b, want 00/0", grant, grant_valid);
    end
    checks++;
    if (grant_idx !== 3'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_idx: idx=%0d timeout=%b, want 0/0", grant_idx, timeout);
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_grant: grant=%h idx=%0d valid=%b, want 01/0/1",
               grant, grant_idx, grant_valid);
    end
    req = 8'h00;
    tick(3);
  endtask

  task automatic test_single();
    apply_reset();
    req = 8'h20;
    tick(1);
    checks++;
    if (grant !== 8'h20 || grant_idx !== 3'd5) begin
      failures++;
      $display("FAIL single_grant: grant=%h idx=%0d, want 20/5", grant, grant_idx);
    end
    tick(1);
    checks++;
    if (grant !== 8'h20) begin
      failures++;
      $display("FAIL single_hold: grant=%h, want 20", grant);
    end
    req = 8'h00;
    tick(1);
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant=%h valid=%b, want 00/0", grant, grant_valid);
    end
    req = 8'h20;
    tick(1);
    checks++;
    if (grant !== 8'h00) begin
      failures++;
      $display("FAIL single_turnaround: grant=%h, want 00", grant);
    end
    tick(1);
    checks++;
    if (grant !== 8'h20 || grant_idx !== 3'd5) begin
      failures++;
      $display("FAIL single_regrant: grant=%h idx=%0d, want 20/5", grant, grant_idx);
    end
    req = 8'h00;
    tick(3);
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    int         k;
    apply_reset();
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      k   = n % 8;
      exp = 8'h01 << k;
      tick(1);
      checks++;
      if (grant !== exp || grant_idx !== 3'(k)) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: grant=%h idx=%0d, want %h/%0d",
                 n, grant, grant_idx, exp, k);
      end
      tick(2);
      checks++;
      if (grant !== exp) begin
        failures++;
        $display("FAIL rotation_hold[%0d]: grant=%h, want %h", n, grant, exp);
      end
      req[k] = 1'b0;
      tick(1);
      checks++;
      if (grant !== 8'h00) begin
        failures++;
        $display("FAIL rotation_release[%0d]: grant=%h, want 00", n, grant);
      end
      req[k] = 1'b1;
      tick(1);
    end
    req = 8'h00;
    tick(3);
  endtask

  task automatic test_priority();
    apply_reset();
    req = 8'h40;
    tick(1);
    checks++;
    if (grant !== 8'h40 || grant_idx !== 3'd6) begin
      failures++;
      $display("FAIL prio_owner6: grant=%h idx=%0d, want 40/6", grant, grant_idx);
    end
    req = 8'h41;
    tick(1);
    checks++;
    if (grant !== 8'h40) begin
      failures++;
      $display("FAIL prio_no_preempt: grant=%h, want 40", grant);
    end
    req = 8'h01;
    tick(1);
    checks++;
    if (grant !== 8'h00) begin
      failures++;
      $display("FAIL prio_release: grant=%h, want 00", grant);
    end
    req = 8'h41;
    tick(2);
    checks++;
    if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL prio_wrap_to_0: grant=%h idx=%0d, want 01/0", grant, grant_idx);
    end
    req = 8'h40;
    tick(3);
    checks++;
    if (grant !== 8'h40 || grant_idx !== 3'd6) begin
      failures++;
      $display("FAIL prio_then_6: grant=%h idx=%0d, want 40/6", grant, grant_idx);
    end
    req = 8'h00;
    tick(3);
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 8'h08;
    tick(1);
    checks++;
    if (grant !== 8'h08) begin
      failures++;
      $display("FAIL async_pre: grant=%h, want 08", grant);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL async_drop: grant=%h valid=%b idx=%0d, want 00/0/0",
               grant, grant_valid, grant_idx);
    end
    req = 8'hFF;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL async_restart: grant=%h idx=%0d, want 01/0", grant, grant_idx);
    end
    req = 8'h00;
    tick(3);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req = 8'h03;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      checks++;
      if (grant !== 8'h01 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_hold0[%0d]: grant=%h timeout=%b, want 01/0", c, grant, timeout);
      end
    end
    tick(1);
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: grant=%h timeout=%b, want 00/1", grant, timeout);
    end
    tick(1);
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_single_pulse: grant=%h timeout=%b, want 00/0", grant, timeout);
    end
    tick(1);
    checks++;
    if (grant !== 8'h02 || grant_idx !== 3'd1) begin
      failures++;
      $display("FAIL timeout_next_owner: grant=%h idx=%0d, want 02/1", grant, grant_idx);
    end
    tick(4);
    checks++;
    if (grant !== 8'h00 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse2: grant=%h timeout=%b, want 00/1", grant, timeout);
    end
    tick(2);
    checks++;
    if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL timeout_recompete: grant=%h idx=%0d, want 01/0", grant, grant_idx);
    end
    req = 8'h00;
    tick(3);
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    req = 8'h03;
    tick(1);
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (grant !== 8'h01 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL no_timeout_hold[%0d]: grant=%h timeout=%b, want 01/0", c, grant, timeout);
        break;
      end
      tick(1);
    end
    req = 8'h00;
    tick(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_priority();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
